mcu_run_ctrl: RTL and testbench

Execution controller for the single-cycle MCU. It produces the clock-enable that gates every state update of the datapath: program counter, register file and data memory. It supports halt, free-run, single-step and a PC breakpoint, and keeps a retired-instruction counter for the LCD debug pages. It sits between the debounced front-panel pulses (button edge, rotary decode) and the MCU clock-enable input.

---
 rtl/mcu_run_ctrl.sv | 108 ++++++++++
 tb/tb_mcu_run_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mcu_run_ctrl.sv
// ============================================================================
// Module      : mcu_run_ctrl
// Description : Execution controller for the single-cycle MCU. It supports
//               halt, run, single-step and a PC breakpoint, and it keeps a
//               retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcu_run_ctrl #(
    parameter int PC_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nClear,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             bp_hit,
    output logic [CNT_W-1:0] retired
);

    localparam logic [1:0] c_S_HALT = 2'b00;
    localparam logic [1:0] c_S_RUN  = 2'b01;
    localparam logic [1:0] c_S_STEP = 2'b10;
    localparam logic [1:0] c_S_BRK  = 2'b11;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             r_skip;
    logic             r_bp_hit;
    logic [CNT_W-1:0] r_retired;
    logic             w_brk;
    logic             w_cpu_en;

    // State register: async reset drops cpu_en at once because the decode is combinational
    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            r_state <= c_S_HALT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_HALT, c_S_BRK: begin
                if (run_req) begin
                    w_state_next = c_S_RUN;
                end else if (step_req) begin
                    w_state_next = c_S_STEP;
                end
            end
            c_S_RUN: begin
                if (run_req) begin
                    w_state_next = c_S_HALT;
                end else if (w_brk) begin
                    w_state_next = c_S_BRK;
                end
            end
            c_S_STEP: w_state_next = c_S_HALT;
            default:  w_state_next = c_S_HALT;
        endcase
    end

    // skip masks the breakpoint only at the instruction being resumed from
    always_comb begin
        w_brk    = bp_en & (pc == bp_addr) & ~r_skip;
        w_cpu_en = (r_state == c_S_STEP) | ((r_state == c_S_RUN) & ~w_brk);
    end

    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            r_skip    <= 1'b0;
            r_bp_hit  <= 1'b0;
            r_retired <= '0;
        end else begin
            if ((w_state_next == c_S_RUN) && (r_state != c_S_RUN)) begin
                r_skip <= 1'b1;
            end else if ((r_state == c_S_RUN) && w_cpu_en) begin
                r_skip <= 1'b0;
            end

            if ((r_state == c_S_RUN) && (w_state_next == c_S_BRK)) begin
                r_bp_hit <= 1'b1;
            end else if ((r_state == c_S_BRK) && (run_req || step_req)) begin
                r_bp_hit <= 1'b0;
            end

            if (w_cpu_en) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign cpu_en  = w_cpu_en;
    assign state   = r_state;
    assign bp_hit  = r_bp_hit;
    assign retired = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_mcu_run_ctrl.sv
// ============================================================================
// Module      : tb_mcu_run_ctrl
// Description : Self-checking bench for mcu_run_ctrl, using a vector table
//               plus hand-written reset and counter-wrap sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcu_run_ctrl;

    logic        clk = 1'b0;
    logic        nClear = 1'b0;
    logic        run_req = 1'b0;
    logic        step_req = 1'b0;
    logic        bp_en = 1'b0;
    logic [15:0] bp_addr = '0;
    logic [15:0] pc = '0;
    logic        loop_en = 1'b0;
    logic        cpu_en;
    logic [1:0]  state;
    logic        bp_hit;
    logic [15:0] retired;

    int checks = 0;
    int failures = 0;

    mcu_run_ctrl #(.PC_W(16), .CNT_W(16)) dut (
        .clk      (clk),
        .nClear   (nClear),
        .run_req  (run_req),
        .step_req (step_req),
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .pc       (pc),
        .cpu_en   (cpu_en),
        .state    (state),
        .bp_hit   (bp_hit),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: straight-line code, with an optional jump 0x0007 -> 0x0005
    always @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            pc <= 16'h0000;
        end else if (cpu_en) begin
            pc <= (loop_en && pc == 16'h0007) ? 16'h0005 : pc + 16'h0001;
        end
    end

    typedef struct {
        logic        rst;
        logic        run;
        logic        step;
        logic        bpen;
        logic [15:0] bpa;
        logic        loop;
        logic        en;
        logic [1:0]  st;
        logic        hit;
        logic [15:0] ret;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        nClear = 1'b0;
        #1;
        nClear = 1'b1;
    endtask

    initial begin
        // Section A: three single steps, four cycles apart
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(vec_t'{1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 2'd2, 1'b0, 16'(k)});
            tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 2'd0, 1'b0, 16'(k + 1)});
            tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 1'b0, 16'(k + 1)});
            tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 1'b0, 16'(k + 1)});
        end
        // Section B: run into breakpoint at 0x0005, resume, loop back, break again, step off
        tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b1, 16'h5, 1'b1, 1'b0, 2'd1, 1'b0, 16'd0});
        for (int i = 1; i <= 5; i++)
            tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 16'h5, 1'b1, 1'b1, 2'd1, 1'b0, 16'(i)});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 16'h5, 1'b1, 1'b0, 2'd3, 1'b1, 16'd5});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 16'h5, 1'b1, 1'b0, 2'd3, 1'b1, 16'd5});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b1, 16'h5, 1'b1, 1'b0, 2'd1, 1'b0, 16'd5});
        for (int i = 6; i <= 8; i++)
            tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 16'h5, 1'b1, 1'b1, 2'd1, 1'b0, 16'(i)});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 16'h5, 1'b1, 1'b0, 2'd3, 1'b1, 16'd8});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b1, 1'b1, 16'h5, 1'b1, 1'b0, 2'd2, 1'b0, 16'd8});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 16'h5, 1'b1, 1'b1, 2'd0, 1'b0, 16'd9});
        // Section C: simultaneous requests, step ignored in RUN, halt retires its instruction
        tbl.push_back(vec_t'{1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 2'd1, 1'b0, 16'd0});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 2'd1, 1'b0, 16'd1});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 2'd1, 1'b0, 16'd2});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 2'd0, 1'b0, 16'd3});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 1'b0, 16'd3});

        // Reset state, held across an edge
        #2;
        chk("reset_cpu_en", 32'(cpu_en), 32'd0);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_retired", 32'(retired), 32'd0);
        tick();
        chk("reset_hold_state", 32'(state), 32'd0);
        chk("reset_hold_bp_hit", 32'(bp_hit), 32'd0);
        nClear = 1'b1;

        foreach (tbl[i]) begin
            if (tbl[i].rst) pulse_reset();
            run_req  = tbl[i].run;
            step_req = tbl[i].step;
            bp_en    = tbl[i].bpen;
            bp_addr  = tbl[i].bpa;
            loop_en  = tbl[i].loop;
            #1;
            chk($sformatf("row%0d_cpu_en", i), 32'(cpu_en), 32'(tbl[i].en));
            tick();
            chk($sformatf("row%0d_state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("row%0d_bp_hit", i), 32'(bp_hit), 32'(tbl[i].hit));
            chk($sformatf("row%0d_retired", i), 32'(retired), 32'(tbl[i].ret));
        end
        run_req = 1'b0; step_req = 1'b0; bp_en = 1'b0; loop_en = 1'b0;

        // Asynchronous reset mid-RUN with retired = 0x0123
        pulse_reset();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        repeat (16'h0123) tick();
        chk("midrun_retired", 32'(retired), 32'h0123);
        chk("midrun_cpu_en", 32'(cpu_en), 32'd1);
        #2;
        nClear = 1'b0;
        #1;
        chk("async_cpu_en", 32'(cpu_en), 32'd0);
        chk("async_state", 32'(state), 32'd0);
        chk("async_retired", 32'(retired), 32'd0);
        nClear = 1'b1;
        tick();

        // Asynchronous reset from BRK clears bp_hit without an edge
        bp_en = 1'b1; bp_addr = 16'h0002;
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        repeat (3) tick();
        chk("brk_state", 32'(state), 32'd3);
        chk("brk_bp_hit", 32'(bp_hit), 32'd1);
        #2;
        nClear = 1'b0;
        #1;
        chk("async_bp_hit", 32'(bp_hit), 32'd0);
        chk("async_brk_state", 32'(state), 32'd0);
        nClear = 1'b1;
        bp_en = 1'b0;
        tick();

        // Counter wrap: run to 0xFFFE, then two steps
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        repeat (16'hFFFD) tick();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk("preload_retired", 32'(retired), 32'hFFFE);
        chk("preload_state", 32'(state), 32'd0);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        chk("wrap_step1", 32'(retired), 32'hFFFF);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        chk("wrap_step2", 32'(retired), 32'h0000);
        chk("wrap_state", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
